// File: rtl/spi_multi_master.sv
// Shared SPI byte engine: one MOSI/MISO pair, per-device SCLK, chip select and divider.
// Byte-level valid/ready commands; CS is held across bytes until a byte marked last.
module spi_multi_master #(
    parameter int                   NUM_DEV  = 2,
    parameter int                   DEV_W    = 1,
    parameter logic [8*NUM_DEV-1:0] DIV_LIST = {8'd2, 8'd1}
) (
    input  logic               I_clk,
    input  logic               I_rst_n,
    input  logic               I_tx_valid,
    output logic               O_tx_ready,
    input  logic [DEV_W-1:0]   I_tx_dev,
    input  logic [7:0]         I_tx_data,
    input  logic               I_tx_last,
    input  logic               I_tx_nocs,
    output logic               O_rx_valid,
    output logic [7:0]         O_rx_data,
    output logic               O_busy,
    output logic [NUM_DEV-1:0] O_spi_clk,
    output logic               O_spi_mosi,
    input  logic               I_spi_miso,
    output logic [NUM_DEV-1:0] O_cs_n
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    function automatic logic [NUM_DEV-1:0] dev_mask(input logic [DEV_W-1:0] dev);
        logic [NUM_DEV-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_DEV; i++)
            if (dev == DEV_W'(i)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [7:0] div_of(input logic [DEV_W-1:0] dev);
        logic [7:0] d;
        d = 8'd1;
        for (int i = 0; i < NUM_DEV; i++)
            if (dev == DEV_W'(i)) d = DIV_LIST[8*i +: 8];
        return d;
    endfunction

    function automatic logic dev_ok(input logic [DEV_W-1:0] dev);
        return 32'(dev) < 32'(NUM_DEV);
    endfunction

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, div_q;
    logic               phase_q;
    logic [2:0]         bit_q;
    logic               held_q;
    logic [DEV_W-1:0]   held_dev_q;
    logic               pend_q;
    logic [NUM_DEV-1:0] cs_n_q, sclk_q;
    logic               mosi_q, rx_valid_q;
    logic [7:0]         rx_data_q;
    logic [DEV_W-1:0]   cmd_dev;
    logic [7:0]         cmd_data, rx_sh;
    logic               cmd_last, cmd_nocs;

    logic             accept, tick, sclk_rise, byte_done;
    logic             enter_setup, enter_shift, enter_gap;
    logic [DEV_W-1:0] new_dev;
    logic [7:0]       new_data;
    logic             new_nocs;

    assign O_tx_ready = (state_q == IDLE);
    assign accept     = I_tx_valid && O_tx_ready;
    assign tick       = (cnt_q == div_q - 8'd1);
    assign sclk_rise  = (state_q == SHIFT) && tick && !phase_q;
    assign byte_done  = (state_q == SHIFT) && tick && phase_q && (bit_q == 3'd7);

    // From IDLE the command comes straight off the port; from GAP it is the latched one.
    assign new_dev  = (state_q == IDLE) ? I_tx_dev  : cmd_dev;
    assign new_data = (state_q == IDLE) ? I_tx_data : cmd_data;
    assign new_nocs = (state_q == IDLE) ? I_tx_nocs : cmd_nocs;

    assign enter_setup = (state_d == SETUP) && (state_q != SETUP);
    assign enter_shift = (state_d == SHIFT) && (state_q != SHIFT);
    assign enter_gap   = (state_d == GAP)   && (state_q != GAP);

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && dev_ok(I_tx_dev)) begin
                    if (held_q && (held_dev_q != I_tx_dev || I_tx_nocs)) state_d = GAP;
                    else if (held_q || I_tx_nocs)                       state_d = SHIFT;
                    else                                                state_d = SETUP;
                end
            end
            SETUP: if (tick) state_d = SHIFT;
            SHIFT: if (byte_done) state_d = (cmd_last && !cmd_nocs) ? HOLD : IDLE;
            HOLD:  if (tick) state_d = GAP;
            GAP: begin
                if (tick) begin
                    if (!pend_q)       state_d = IDLE;
                    else if (cmd_nocs) state_d = SHIFT;
                    else               state_d = SETUP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            cnt_q      <= '0;
            div_q      <= 8'd1;
            phase_q    <= 1'b0;
            bit_q      <= '0;
            held_q     <= 1'b0;
            held_dev_q <= '0;
            pend_q     <= 1'b0;
            cs_n_q     <= '1;
            sclk_q     <= '0;
            mosi_q     <= 1'b1;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            cnt_q      <= (state_d != state_q || tick) ? 8'd0 : cnt_q + 8'd1;

            // Out-of-range device: swallow the command, answer with all-ones.
            if (accept && !dev_ok(I_tx_dev)) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= 8'hFF;
            end

            if (enter_gap) begin
                cs_n_q <= '1;
                held_q <= 1'b0;
                pend_q <= (state_q == IDLE);
                // Releasing a held CS times the gap with the old device's divider.
                if (state_q == IDLE) div_q <= div_of(held_dev_q);
            end

            if (enter_setup) begin
                cs_n_q <= ~dev_mask(new_dev);
                div_q  <= div_of(new_dev);
            end

            if (enter_shift) begin
                div_q   <= div_of(new_dev);
                phase_q <= 1'b0;
                bit_q   <= '0;
                mosi_q  <= new_nocs ? 1'b1 : new_data[7];
            end

            if (state_q == SHIFT && tick) begin
                if (!phase_q) begin
                    phase_q <= 1'b1;
                    sclk_q  <= dev_mask(cmd_dev);
                end else begin
                    phase_q <= 1'b0;
                    sclk_q  <= '0;
                    if (bit_q == 3'd7) begin
                        mosi_q     <= 1'b1;
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= rx_sh;
                        if (!(cmd_last && !cmd_nocs)) begin
                            held_q     <= !cmd_nocs;
                            held_dev_q <= cmd_dev;
                        end
                    end else begin
                        bit_q  <= bit_q + 3'd1;
                        mosi_q <= cmd_nocs ? 1'b1 : cmd_data[3'd6 - bit_q];
                    end
                end
            end
        end
    end

    always_ff @(posedge I_clk) begin
        if (accept) begin
            cmd_dev  <= I_tx_dev;
            cmd_data <= I_tx_data;
            cmd_last <= I_tx_last;
            cmd_nocs <= I_tx_nocs;
        end
        if (sclk_rise) rx_sh <= {rx_sh[6:0], I_spi_miso};
    end

    assign O_rx_valid = rx_valid_q;
    assign O_rx_data  = rx_data_q;
    assign O_busy     = (state_q != IDLE) || !(&cs_n_q);
    assign O_spi_clk  = sclk_q;
    assign O_spi_mosi = mosi_q;
    assign O_cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_multi_master.sv
// Scoreboard bench for spi_multi_master: dev0 D=1, dev1 D=2, DEV_W=2 so index 3 is reachable.
module tb_spi_multi_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [1:0] tx_dev = '0;
    logic [7:0] tx_data = '0;
    logic       tx_last = 1'b0;
    logic       tx_nocs = 1'b0;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic [1:0] spi_clk;
    logic       spi_mosi;
    logic       spi_miso;
    logic [1:0] cs_n;
    logic       miso_inv = 1'b0;

    assign spi_miso = spi_mosi ^ miso_inv;

    always #5 clk = ~clk;

    spi_multi_master #(.NUM_DEV(2), .DEV_W(2), .DIV_LIST({8'd2, 8'd1})) dut (
        .I_clk(clk), .I_rst_n(rst_n),
        .I_tx_valid(tx_valid), .O_tx_ready(tx_ready), .I_tx_dev(tx_dev),
        .I_tx_data(tx_data), .I_tx_last(tx_last), .I_tx_nocs(tx_nocs),
        .O_rx_valid(rx_valid), .O_rx_data(rx_data), .O_busy(busy),
        .O_spi_clk(spi_clk), .O_spi_mosi(spi_mosi), .I_spi_miso(spi_miso), .O_cs_n(cs_n)
    );

    logic [7:0] exp_q[$];
    int n_pass = 0, n_tot = 0;
    int sb_pass = 0, sb_tot = 0;
    int sclk_rise[2] = '{0, 0};
    int cs_fall[2]   = '{0, 0};
    int cs_rise[2]   = '{0, 0};
    int overlap = 0, mosi_low = 0, cs_low = 0, rx_cnt = 0;
    logic [1:0] prev_sclk = '0;
    logic [1:0] prev_cs = 2'b11;

    // Monitor: pin activity counters and scoreboard pops on every rx_valid.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (spi_clk[i] && !prev_sclk[i]) sclk_rise[i]++;
            if (!cs_n[i] && prev_cs[i])      cs_fall[i]++;
            if (cs_n[i] && !prev_cs[i])      cs_rise[i]++;
        end
        prev_sclk = spi_clk;
        prev_cs   = cs_n;
        if (cs_n == 2'b00) overlap++;
        if (!spi_mosi)     mosi_low++;
        if (cs_n != 2'b11) cs_low++;
        if (rx_valid) begin
            logic [7:0] e;
            rx_cnt++;
            sb_tot++;
            if (exp_q.size() == 0) begin
                $display("FAIL rx_unexpected: got %02h, nothing expected", rx_data);
            end else begin
                e = exp_q.pop_front();
                if (rx_data === e) sb_pass++;
                else $display("FAIL rx_data: got %02h expected %02h", rx_data, e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send(input logic [1:0] dev, input logic [7:0] data, input logic last,
                        input logic nocs, input logic exp_rx, input logic [7:0] exp_byte);
        int t = 0;
        while (!tx_ready && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 2000) chk("ready_timeout", 32'(tx_ready), 32'd1);
        tx_valid = 1'b1; tx_dev = dev; tx_data = data; tx_last = last; tx_nocs = nocs;
        if (exp_rx) exp_q.push_back(exp_byte);
        @(posedge clk); #1;
        tx_valid = 1'b0; tx_data = ~data;
    endtask

    task automatic wait_rx(input int start, output int n);
        n = start;
        do begin
            @(negedge clk);
            n++;
        end while (!rx_valid && n < 2000);
    endtask

    task automatic send_meas(input logic [1:0] dev, input logic [7:0] data, input logic last,
                             input logic nocs, input logic [7:0] exp_byte, output int lat);
        send(dev, data, last, nocs, 1'b1, exp_byte);
        wait_rx(0, lat);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int lat, n, g, bad;
        int s_sclk0, s_sclk1, s_csf0, s_csf1, s_csr0, s_csr1, s_ovl, s_mosi, s_csl, s_rx;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(cs_n), 32'h3);
        chk("rst_sclk", 32'(spi_clk), 32'h0);
        chk("rst_mosi", 32'(spi_mosi), 32'h1);
        chk("rst_rx_valid", 32'(rx_valid), 32'h0);
        chk("rst_rx_data", 32'(rx_data), 32'h0);
        chk("rst_ready_busy", {30'd0, tx_ready, busy}, 32'h2);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: dev0 D=1, A5, last
        s_sclk0 = sclk_rise[0]; s_sclk1 = sclk_rise[1];
        send(2'd0, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5);
        @(negedge clk);
        chk("t1_cs_setup", 32'(cs_n), 32'h2);
        wait_rx(1, lat);
        chk("t1_latency", lat, 18);
        chk("t1_cs_hold", 32'(cs_n), 32'h2);
        @(negedge clk);
        chk("t1_cs_release", 32'(cs_n), 32'h3);
        chk("t1_sclk0_pulses", sclk_rise[0] - s_sclk0, 8);
        chk("t1_sclk1_pulses", sclk_rise[1] - s_sclk1, 0);
        wait_idle();

        // 2: dev1 D=2, three bytes, CS held
        s_sclk0 = sclk_rise[0]; s_sclk1 = sclk_rise[1];
        s_csf0 = cs_fall[0]; s_csr0 = cs_rise[0]; s_csf1 = cs_fall[1]; s_csr1 = cs_rise[1];
        send_meas(2'd1, 8'h3C, 1'b0, 1'b0, 8'h3C, lat);
        chk("t2_lat_first", lat, 35);
        send_meas(2'd1, 8'hC3, 1'b0, 1'b0, 8'hC3, lat);
        chk("t2_lat_held", lat, 33);
        send_meas(2'd1, 8'h5A, 1'b1, 1'b0, 8'h5A, lat);
        chk("t2_lat_last", lat, 33);
        wait_idle();
        chk("t2_sclk1_pulses", sclk_rise[1] - s_sclk1, 24);
        chk("t2_cs1_falls", cs_fall[1] - s_csf1, 1);
        chk("t2_cs1_rises", cs_rise[1] - s_csr1, 1);
        chk("t2_dev0_quiet", (sclk_rise[0] - s_sclk0) + (cs_fall[0] - s_csf0) + (cs_rise[0] - s_csr0), 0);

        // 3: held CS1, then switch to dev0
        s_ovl = overlap;
        send_meas(2'd1, 8'h11, 1'b0, 1'b0, 8'h11, lat);
        chk("t3_cs1_held", 32'(cs_n), 32'h1);
        send(2'd0, 8'h22, 1'b1, 1'b0, 1'b1, 8'h22);
        n = 0; g = 0;
        do begin
            @(negedge clk);
            n++;
            if (cs_n == 2'b11) g++;
        end while (cs_n[0] && n < 200);
        chk("t3_gap_cycles", g, 2);
        chk("t3_cs0_fall_cycle", n, 3);
        wait_rx(n, lat);
        chk("t3_latency", lat, 20);
        wait_idle();
        chk("t3_no_overlap", overlap - s_ovl, 0);

        // 4: ten nocs bytes on dev1
        s_sclk0 = sclk_rise[0]; s_sclk1 = sclk_rise[1]; s_mosi = mosi_low; s_csl = cs_low;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            send_meas(2'd1, 8'(i * 37), (i == 9), 1'b1, 8'hFF, lat);
            if (lat != 33) bad++;
        end
        wait_idle();
        chk("t4_lat_all", bad, 0);
        chk("t4_sclk1_pulses", sclk_rise[1] - s_sclk1, 80);
        chk("t4_sclk0_pulses", sclk_rise[0] - s_sclk0, 0);
        chk("t4_mosi_low", mosi_low - s_mosi, 0);
        chk("t4_cs_low", cs_low - s_csl, 0);

        // MISO independent of MOSI
        miso_inv = 1'b1;
        send_meas(2'd0, 8'h3C, 1'b1, 1'b0, 8'hC3, lat);
        chk("inv_latency", lat, 18);
        wait_idle();
        miso_inv = 1'b0;

        // 5: reset in the middle of bit 4
        send(2'd1, 8'h96, 1'b1, 1'b0, 1'b0, 8'h00);
        repeat (20) @(negedge clk);
        chk("t5_cs_before", 32'(cs_n), 32'h1);
        s_rx = rx_cnt;
        rst_n = 1'b0;
        #1;
        chk("t5_cs_async", 32'(cs_n), 32'h3);
        chk("t5_sclk_async", 32'(spi_clk), 32'h0);
        chk("t5_mosi_async", 32'(spi_mosi), 32'h1);
        chk("t5_rx_data_async", 32'(rx_data), 32'h0);
        chk("t5_ready_busy", {30'd0, tx_ready, busy}, 32'h2);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("t5_no_rx", rx_cnt - s_rx, 0);
        send_meas(2'd1, 8'h5A, 1'b1, 1'b0, 8'h5A, lat);
        chk("t5_after_latency", lat, 35);
        wait_idle();

        // 6: out-of-range device while CS1 held
        send_meas(2'd1, 8'h77, 1'b0, 1'b0, 8'h77, lat);
        s_sclk0 = sclk_rise[0]; s_sclk1 = sclk_rise[1]; s_mosi = mosi_low;
        s_csf0 = cs_fall[0] + cs_rise[0] + cs_fall[1] + cs_rise[1];
        send_meas(2'd3, 8'hAB, 1'b1, 1'b0, 8'hFF, lat);
        chk("t6_drop_latency", lat, 1);
        send_meas(2'd2, 8'h00, 1'b0, 1'b1, 8'hFF, lat);
        chk("t6_drop_nocs_latency", lat, 1);
        @(negedge clk);
        chk("t6_cs_still_held", 32'(cs_n), 32'h1);
        chk("t6_pins_static", (sclk_rise[0] - s_sclk0) + (sclk_rise[1] - s_sclk1) + (mosi_low - s_mosi)
            + (cs_fall[0] + cs_rise[0] + cs_fall[1] + cs_rise[1] - s_csf0), 0);
        send_meas(2'd1, 8'h0F, 1'b1, 1'b0, 8'h0F, lat);
        chk("t6_held_latency", lat, 33);
        wait_idle();
        chk("t6_cs_final", 32'(cs_n), 32'h3);

        repeat (4) @(negedge clk);
        chk("sb_queue_empty", exp_q.size(), 0);
        n_pass += sb_pass;
        n_tot  += sb_tot;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
